// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP sample FIFO slice.
//   DEF_PKT_WIDTH : default sample width
//   sample_t      : sample word at the default width
//   level_width() : width of an occupancy counter that must hold 0..DEPTH
//   ch_width()    : channel tag width, never narrower than one bit
package dsp_pkg;

    localparam int DEF_PKT_WIDTH = 16;

    typedef logic [DEF_PKT_WIDTH-1:0] sample_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/dsp_sample_fifo_change_detect.sv
// Per-channel change detector for the sample FIFO head.
// Holds the last sample popped on each channel and flags when the current
// head differs from the last one popped on the same channel.
//   i_clk, i_rst_n : clock, async active-low reset (clears history to 0)
//   i_pop          : a pop happens on this edge; record i_pkt for i_ch
//   i_valid        : head is valid
//   i_ch, i_pkt    : head channel tag and sample
//   o_changed      : head valid and differs from last popped on its channel
module change_detect
    import dsp_pkg::*;
#(
    parameter int PKT_WIDTH = DEF_PKT_WIDTH,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = ch_width(NUM_CH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pop,
    input  logic                 i_valid,
    input  logic [CH_W-1:0]      i_ch,
    input  logic [PKT_WIDTH-1:0] i_pkt,
    output logic                 o_changed
);

    logic [CH_W-1:0]      w_idx;
    logic [PKT_WIDTH-1:0] r_last [NUM_CH];

    // Out-of-range tags fold back onto a real channel slot.
    assign w_idx = CH_W'(32'(i_ch) % 32'(NUM_CH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_last[i] <= '0;
            end
        end else if (i_pop) begin
            r_last[w_idx] <= i_pkt;
        end
    end

    assign o_changed = i_valid && (i_pkt != r_last[w_idx]);

endmodule

// File: rtl/dsp_sample_fifo.sv
// First-word fall-through sample FIFO with channel tags, optional
// drop-oldest overwrite, sticky overflow flag and per-channel change flag.
//   clkDSP_i, rstDSP_n_i        : clock, async active-low reset
//   pktIn_i, chIn_i, validIn_i  : write side, accepted when readyIn_o
//   readyIn_o                   : write accept (always 1 when OVERWRITE=1)
//   pktOut_o, chOut_o           : head entry, meaningful when validOut_o
//   validOut_o, readyOut_i      : read handshake
//   pktChanged_o                : head differs from last pop on its channel
//   level_o, almostFull_o       : occupancy and level >= DEPTH-2
//   overflow_o, clrFlags_i      : sticky overflow, synchronous clear
module dsp_sample_fifo
    import dsp_pkg::*;
#(
    parameter int  PKT_WIDTH = DEF_PKT_WIDTH,
    parameter int  DEPTH     = 8,
    parameter int  NUM_CH    = 2,
    parameter int  OVERWRITE = 1,
    localparam int CH_W      = ch_width(NUM_CH),
    localparam int LW        = level_width(DEPTH)
) (
    input  logic                 clkDSP_i,
    input  logic                 rstDSP_n_i,
    input  logic [PKT_WIDTH-1:0] pktIn_i,
    input  logic [CH_W-1:0]      chIn_i,
    input  logic                 validIn_i,
    output logic                 readyIn_o,
    output logic [PKT_WIDTH-1:0] pktOut_o,
    output logic [CH_W-1:0]      chOut_o,
    output logic                 validOut_o,
    input  logic                 readyOut_i,
    output logic                 pktChanged_o,
    output logic [LW-1:0]        level_o,
    output logic                 almostFull_o,
    output logic                 overflow_o,
    input  logic                 clrFlags_i
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [PKT_WIDTH-1:0] pkt;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_evict;
    logic            w_drop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);

    assign readyIn_o = (OVERWRITE != 0) ? 1'b1 : !w_full;

    assign w_push  = validIn_i && readyIn_o;
    // Head is only valid once a write has landed, so a push into an empty
    // FIFO never pops in the same cycle.
    assign w_pop   = !w_empty && readyOut_i;
    // A push into a full FIFO with no pop discards the oldest entry.
    assign w_evict = w_push && w_full && !w_pop;
    assign w_drop  = validIn_i && !readyIn_o;

    always_ff @(posedge clkDSP_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{ch: chIn_i, pkt: pktIn_i};
        end
    end

    always_ff @(posedge clkDSP_i or negedge rstDSP_n_i) begin
        if (!rstDSP_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push && !w_evict, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_evict || w_drop) begin
                r_overflow <= 1'b1;
            end else if (clrFlags_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign pktOut_o     = r_mem[r_rd_ptr].pkt;
    assign chOut_o      = r_mem[r_rd_ptr].ch;
    assign validOut_o   = !w_empty;
    assign level_o      = r_level;
    assign almostFull_o = (r_level >= LW'(DEPTH - 2));
    assign overflow_o   = r_overflow;

    change_detect #(
        .PKT_WIDTH (PKT_WIDTH),
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W)
    ) u_change_detect (
        .i_clk     (clkDSP_i),
        .i_rst_n   (rstDSP_n_i),
        .i_pop     (w_pop),
        .i_valid   (validOut_o),
        .i_ch      (chOut_o),
        .i_pkt     (pktOut_o),
        .o_changed (pktChanged_o)
    );

endmodule

// File: doc/dsp_sample_fifo.md
DSP_SAMPLE_FIFO -- requirements
Module: dsp_sample_fifo

Interface
REQ-001 Parameter PKT_WIDTH, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 8: entries; power of two, >= 2.
REQ-003 Parameter NUM_CH, default 2: channel count; CH_W = max(1, clog2(NUM_CH)).
REQ-004 Parameter OVERWRITE, default 1: 1 = drop oldest on full; 0 = backpressure.
REQ-005 clkDSP_i  in  1  sole clock, all logic on rising edge; one clock, no CDC.
REQ-006 rstDSP_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 pktIn_i  in  PKT_WIDTH  write sample.
REQ-008 chIn_i  in  CH_W  channel tag of write sample.
REQ-009 validIn_i  in  1  write request.
REQ-010 readyIn_o  out  1  write accepted when validIn_i && readyIn_o.
REQ-011 pktOut_o  out  PKT_WIDTH  head sample (first-word fall-through).
REQ-012 chOut_o  out  CH_W  head channel tag.
REQ-013 validOut_o  out  1  head valid (FIFO not empty).
REQ-014 readyOut_i  in  1  pop when validOut_o && readyOut_i.
REQ-015 pktChanged_o  out  1  head differs from last popped sample of same channel.
REQ-016 level_o  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 almostFull_o  out  1  level_o >= DEPTH-2.
REQ-018 overflow_o  out  1  sticky: sample dropped or oldest overwritten.
REQ-019 clrFlags_i  in  1  synchronous clear of overflow_o.

Function
REQ-020 Storage: DEPTH x (PKT_WIDTH+CH_W) flop array; wrPtr/rdPtr of clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0.
REQ-021 Occupancy counter is separate from pointers; full = (level == DEPTH), empty = (level == 0).
REQ-022 Write-to-head latency: sample pushed into empty FIFO at edge N appears on pktOut_o/validOut_o after edge N (visible in cycle N+1).
REQ-023 pktOut_o, chOut_o combinationally select mem[rdPtr]; value when validOut_o=0 is don't-care.
REQ-024 OVERWRITE=0: readyIn_o = !full; write while full is not accepted, sets overflow_o.
REQ-025 OVERWRITE=1: readyIn_o = 1; write while full and no pop advances rdPtr and wrPtr, level unchanged, sets overflow_o.
REQ-026 Simultaneous push and pop: both pointers advance, level unchanged, no overflow, in all modes (including full).
REQ-027 Pop when empty: no effect, pointers/level unchanged.
REQ-028 Push into empty with simultaneous readyOut_i: push only (head not yet valid).
REQ-029 Per-channel register lastPopped[NUM_CH], PKT_WIDTH each, updated with pktOut_o on each pop at index chOut_o.
REQ-030 pktChanged_o = validOut_o AND (pktOut_o != lastPopped[chOut_o]); strictly 1-bit reduction, no vector truncation.
REQ-031 chIn_i >= NUM_CH: sample still stored; change detection uses index modulo NUM_CH.
REQ-032 overflow_o: set has priority over clrFlags_i in same cycle.

Reset
REQ-033 rstDSP_n_i low asynchronously clears wrPtr, rdPtr, level, overflow_o, lastPopped[*] to 0; memory contents not reset.
REQ-034 During/after reset: validOut_o=0, level_o=0, almostFull_o=0, pktChanged_o=0, readyIn_o=1.
REQ-035 Reset mid-operation discards all queued samples; first post-reset pop with value 0 reports pktChanged_o=0.

Structure
REQ-036 Shared package dsp_pkg holds default PKT_WIDTH, sample typedef, and level-width helper function.
REQ-037 One sub-module, change_detect: lastPopped array plus comparator; storage and pointers stay in top.

Verification
REQ-038 Reset, push 0x1234 ch0 -> next cycle validOut_o=1, pktOut_o=0x1234, pktChanged_o=1, level_o=1.
REQ-039 Push 8 samples, readyOut_i=0, OVERWRITE=0 -> level_o=8, readyIn_o=0, 9th push dropped, overflow_o=1, head unchanged.
REQ-040 OVERWRITE=1, fill 8 (values 1..8), push 9 -> level_o=8, head=2, overflow_o=1; clrFlags_i -> overflow_o=0.
REQ-041 Full, push+pop same cycle -> level_o stays 8, overflow_o stays 0, head advances by one.
REQ-042 ch0 pops 0x00AA then head 0x00AA ch0 -> pktChanged_o=0; head 0x00AA ch1 -> pktChanged_o=1.
REQ-043 Assert rstDSP_n_i low mid-burst with level_o=5, no clock edge -> validOut_o=0, level_o=0 immediately.
